// File: rtl/clause_feedback_gen.sv
// Turns one clamped class sum into a per-clause feedback stream: each clause gets an
// LFSR-driven select decision against (T-v)/2T or (T+v)/2T, then a Type I / Type II / none tag.
module clause_feedback_gen #(
    parameter int          NUM_CLAUSES = 16,
    parameter int          THRESHOLD   = 50,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic                           clk,
    input  logic                           rst_n_flag,
    input  logic                           start,
    input  logic signed [31:0]             class_sum_in,
    input  logic                           target,
    input  logic                           stop_flag,
    output logic                           busy,
    output logic                           fb_valid,
    output logic [$clog2(NUM_CLAUSES)-1:0] fb_clause_idx,
    output logic [1:0]                     fb_type,
    output logic                           done
);

    localparam int IW = $clog2(NUM_CLAUSES);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_ISSUE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic signed [31:0] T_S     = 32'(THRESHOLD);
    localparam logic [15:0]        T16     = 16'(THRESHOLD);
    localparam logic [15:0]        T2_16   = 16'(2 * THRESHOLD);
    localparam logic [15:0]        SEED_OK = (LFSR_SEED == 16'h0000) ? 16'hACE1 : LFSR_SEED;

    logic [1:0]    r_state;
    logic [15:0]   r_v;
    logic          r_target;
    logic [15:0]   r_lfsr;
    logic [IW-1:0] r_idx;
    logic [1:0]    r_fb_type;
    logic          r_fb_valid;
    logic          r_busy;
    logic          r_done;

    logic [15:0]   w_v_clamp;
    logic [15:0]   w_num;
    logic [31:0]   w_prod_r;
    logic [31:0]   w_prod_n;
    logic          w_sel;
    logic [IW-1:0] w_emit_idx;
    logic [1:0]    w_type;
    logic [15:0]   w_lfsr_next;
    logic          w_last;

    always_comb begin
        w_v_clamp = class_sum_in[15:0];
        if (class_sum_in > T_S) begin
            w_v_clamp = T16;
        end else if (class_sum_in < -T_S) begin
            w_v_clamp = 16'(-T_S);
        end
    end

    // r_v is two's complement; modular 16-bit arithmetic yields num in 0..2T.
    assign w_num       = r_target ? (T16 - r_v) : (T16 + r_v);
    assign w_prod_r    = {16'h0000, r_lfsr} * {16'h0000, T2_16};
    assign w_prod_n    = {w_num, 16'h0000};
    assign w_sel       = (w_prod_r < w_prod_n);
    assign w_emit_idx  = (r_state == S_LOAD) ? '0 : (r_idx + IW'(1));
    assign w_last      = (r_idx == IW'(NUM_CLAUSES - 1));
    assign w_lfsr_next = {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};

    // Type I goes to clauses whose polarity agrees with the label direction.
    always_comb begin
        w_type = 2'b00;
        if (w_sel) begin
            w_type = (w_emit_idx[0] != r_target) ? 2'b01 : 2'b10;
        end
    end

    always_ff @(posedge clk or negedge rst_n_flag) begin
        if (!rst_n_flag) begin
            r_state    <= S_IDLE;
            r_v        <= 16'h0000;
            r_target   <= 1'b0;
            r_lfsr     <= SEED_OK;
            r_idx      <= '0;
            r_fb_type  <= 2'b00;
            r_fb_valid <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else if (!stop_flag) begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_v      <= w_v_clamp;
                        r_target <= target;
                        r_busy   <= 1'b1;
                        r_state  <= S_LOAD;
                    end
                end
                S_LOAD, S_ISSUE: begin
                    if (r_state == S_ISSUE && w_last) begin
                        r_fb_valid <= 1'b0;
                        r_fb_type  <= 2'b00;
                        r_done     <= 1'b1;
                        r_busy     <= 1'b0;
                        r_state    <= S_DONE;
                    end else begin
                        r_fb_valid <= 1'b1;
                        r_idx      <= w_emit_idx;
                        r_fb_type  <= w_type;
                        r_lfsr     <= w_lfsr_next;
                        r_state    <= S_ISSUE;
                    end
                end
                S_DONE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_v      <= w_v_clamp;
                        r_target <= target;
                        r_busy   <= 1'b1;
                        r_state  <= S_LOAD;
                    end else begin
                        r_state  <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Freeze must blank valid/done in the very cycle it is raised.
    assign busy          = r_busy;
    assign fb_valid      = r_fb_valid & ~stop_flag;
    assign done          = r_done & ~stop_flag;
    assign fb_clause_idx = r_idx;
    assign fb_type       = r_fb_type;

endmodule

// File: tb/tb_clause_feedback_gen.sv
// Directed bench: expected clause/done items are queued at start and checked as the DUT emits them.
module tb_clause_feedback_gen;

    localparam int          NC   = 16;
    localparam int          T    = 50;
    localparam logic [15:0] SEED = 16'hACE1;

    logic              clk;
    logic              rst_n_flag;
    logic              start;
    logic signed [31:0] class_sum_in;
    logic              target;
    logic              stop_flag;
    logic              busy;
    logic              fb_valid;
    logic [3:0]        fb_clause_idx;
    logic [1:0]        fb_type;
    logic              done;

    clause_feedback_gen #(
        .NUM_CLAUSES(NC),
        .THRESHOLD  (T),
        .LFSR_SEED  (SEED)
    ) dut (
        .clk          (clk),
        .rst_n_flag   (rst_n_flag),
        .start        (start),
        .class_sum_in (class_sum_in),
        .target       (target),
        .stop_flag    (stop_flag),
        .busy         (busy),
        .fb_valid     (fb_valid),
        .fb_clause_idx(fb_clause_idx),
        .fb_type      (fb_type),
        .done         (done)
    );

    typedef struct packed {
        logic       is_done;
        logic [3:0] idx;
        logic [1:0] typ;
    } exp_t;

    exp_t        q[$];
    int          tests    = 0;
    int          fails    = 0;
    int          cyc      = 0;
    int          s_cyc    = 0;
    int          done_cnt = 0;
    logic [15:0] m_lfsr   = SEED;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    // Reference: probability num/2T realised as r/65536 < num/(2T).
    task automatic push_run(input int v, input logic tgt);
        int   vc;
        int   num;
        exp_t e;
        vc  = (v > T) ? T : ((v < -T) ? -T : v);
        num = tgt ? (T - vc) : (T + vc);
        for (int k = 0; k < NC; k++) begin
            e.is_done = 1'b0;
            e.idx     = 4'(k);
            if ((longint'(m_lfsr) * 2 * T) < (longint'(num) * 65536))
                e.typ = (((k % 2) == 0) == (tgt == 1'b1)) ? 2'b01 : 2'b10;
            else
                e.typ = 2'b00;
            q.push_back(e);
            m_lfsr = lfsr_step(m_lfsr);
        end
        e = '{is_done: 1'b1, idx: 4'd0, typ: 2'b00};
        q.push_back(e);
    endtask

    always @(negedge clk) begin
        exp_t e;
        exp_t obs;
        if (rst_n_flag) begin
            if (fb_valid) begin
                e   = (q.size() > 0) ? q.pop_front() : exp_t'(7'h7F);
                obs = '{is_done: done, idx: fb_clause_idx, typ: fb_type};
                check("clause", 32'(obs), 32'(e));
            end
            if (done) begin
                e   = (q.size() > 0) ? q.pop_front() : exp_t'(7'h00);
                obs = '{is_done: done, idx: 4'd0, typ: fb_type};
                check("done_marker", 32'(obs), 32'(e));
                check("busy_at_done", 32'(busy), 32'd0);
                done_cnt++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(input int v, input logic tgt);
        push_run(v, tgt);
        class_sum_in = v;
        target       = tgt;
        start        = 1'b1;
        tick();
        start = 1'b0;
        s_cyc = cyc;
        check("busy_after_start", 32'(busy), 32'd1);
    endtask

    // s_cyc is cycle N+1; done lands in N+2+NC, i.e. NC+1 cycles later.
    task automatic wait_done(input string tag, input int exp_lat);
        for (int i = 0; i < 100 && done !== 1'b1; i++) tick();
        check(tag, 32'(cyc - s_cyc), 32'(exp_lat));
    endtask

    initial begin
        rst_n_flag   = 1'b0;
        start        = 1'b0;
        class_sum_in = 0;
        target       = 1'b0;
        stop_flag    = 1'b0;
        tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_valid", 32'(fb_valid), 32'd0);
        check("rst_idx", 32'(fb_clause_idx), 32'd0);
        check("rst_type", 32'(fb_type), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        rst_n_flag = 1'b1;
        tick();

        stop_flag = 1'b1;
        start     = 1'b1;
        tick();
        start     = 1'b0;
        stop_flag = 1'b0;
        check("start_during_stop", 32'(busy), 32'd0);
        tick();
        check("start_during_stop_2", 32'(busy), 32'd0);

        start_run(50, 1'b1);
        wait_done("lat_num0", NC + 1);
        start_run(-50, 1'b1);
        wait_done("lat_num2T", NC + 1);
        start_run(-50, 1'b0);
        wait_done("lat_neg_num0", NC + 1);
        start_run(200, 1'b0);
        wait_done("lat_reclamp", NC + 1);
        start_run(0, 1'b1);
        wait_done("lat_lfsr_a", NC + 1);
        start_run(0, 1'b1);
        wait_done("lat_lfsr_b", NC + 1);

        // Clause 5 is presented in cycle s_cyc+6; freeze it for three cycles.
        start_run(0, 1'b1);
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        stop_flag = 1'b1;
        #3;
        check("stop_valid_0", 32'(fb_valid), 32'd0);
        tick();
        check("stop_valid_1", 32'(fb_valid), 32'd0);
        tick();
        check("stop_valid_2", 32'(fb_valid), 32'd0);
        tick();
        stop_flag = 1'b0;
        #1;
        check("resume_idx", 32'(fb_clause_idx), 32'd5);
        check("resume_valid", 32'(fb_valid), 32'd1);
        wait_done("lat_stop", NC + 1 + 3);

        tick();
        start_run(0, 1'b1);
        for (int i = 0; i < 40 && !(fb_valid === 1'b1 && fb_clause_idx === 4'd7); i++) tick();
        check("reached_idx7", 32'(fb_clause_idx), 32'd7);
        rst_n_flag = 1'b0;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_valid", 32'(fb_valid), 32'd0);
        check("arst_idx", 32'(fb_clause_idx), 32'd0);
        check("arst_type", 32'(fb_type), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        q.delete();
        m_lfsr = SEED;
        begin
            int dc;
            dc = done_cnt;
            tick();
            tick();
            rst_n_flag = 1'b1;
            repeat (25) tick();
            check("no_done_after_abort", 32'(done_cnt), 32'(dc));
        end
        start_run(0, 1'b1);
        wait_done("lat_replay", NC + 1);
        tick();
        tick();
        check("queue_drained", 32'(q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
